// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------------
// i2c_pkg : shared state encoding and bit-timing constants for i2c_byte_tx
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BIT   = 3'd2,
    ACK   = 3'd3,
    STOP  = 3'd4,
    HOLD  = 3'd5
  } i2c_state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int BITS_PER_BYTE = 8;

endpackage

`default_nettype wire

// File: rtl/i2c_scl_timer.sv
// ----------------------------------------------------------------------
// i2c_scl_timer : SCL quarter-period tick generator with optional stretch hold
// Stretch hold active only when I2C_BYTE_TX_STRETCH_EN is defined. Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module i2c_scl_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic stretch_req,
  input  logic scl_i,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] c_last = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_hold;

`ifdef I2C_BYTE_TX_STRETCH_EN
  // SCL has been released but a slave is still holding it low
  assign w_hold = stretch_req & ~scl_i;
`else
  assign w_hold = 1'b0;
  logic w_unused_stretch;
  assign w_unused_stretch = &{1'b0, stretch_req, scl_i};
`endif

  assign tick = (r_cnt == c_last) && !w_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (!w_hold) begin
      r_cnt <= tick ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2c_byte_tx.sv
// ----------------------------------------------------------------------
// i2c_byte_tx : I2C master byte transmitter (START, 8 bits MSB-first, ACK, STOP)
// Clock stretching enabled by defining I2C_BYTE_TX_STRETCH_EN. Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module i2c_byte_tx
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       stop_after,
  input  logic       sda_i,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       load_tx_count,
  output logic       dec_tx_count,
  output logic       data_ack
);

  localparam logic [2:0] c_last_bit = 3'(BITS_PER_BYTE - 1);

  i2c_state_e r_state, w_state_nx;
  logic [1:0] r_phase, w_phase_nx;
  logic [2:0] r_bitcnt, w_bitcnt_nx;
  logic [7:0] r_shift, w_shift_nx;
  logic       r_stop, w_stop_nx;
  logic       r_scl, w_scl_nx, r_sda, w_sda_nx;
  logic       r_busy, w_busy_nx, r_done, w_done_nx, r_ack_err, w_ack_err_nx;
  logic       r_load, w_load_nx, r_dec, w_dec_nx, r_dack, w_dack_nx;
  logic       w_accept, w_tick, w_stretch_req;

  assign w_accept      = start && (r_state == IDLE || r_state == HOLD);
  assign w_stretch_req = r_busy && (r_phase == Q2) && r_scl;

  i2c_scl_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (w_accept),
    .stretch_req (w_stretch_req),
    .scl_i       (scl_i),
    .tick        (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_phase   <= Q0;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_stop    <= 1'b0;
      r_scl     <= 1'b1;
      r_sda     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_load    <= 1'b0;
      r_dec     <= 1'b0;
      r_dack    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_phase   <= w_phase_nx;
      r_bitcnt  <= w_bitcnt_nx;
      r_shift   <= w_shift_nx;
      r_stop    <= w_stop_nx;
      r_scl     <= w_scl_nx;
      r_sda     <= w_sda_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
      r_ack_err <= w_ack_err_nx;
      r_load    <= w_load_nx;
      r_dec     <= w_dec_nx;
      r_dack    <= w_dack_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_phase_nx   = r_phase;
    w_bitcnt_nx  = r_bitcnt;
    w_shift_nx   = r_shift;
    w_stop_nx    = r_stop;
    w_busy_nx    = r_busy;
    w_ack_err_nx = r_ack_err;
    w_done_nx    = 1'b0;
    w_dec_nx     = 1'b0;
    w_dack_nx    = 1'b0;

    case (r_state)
      IDLE, HOLD: begin
        if (w_accept) begin
          w_shift_nx   = tx_data;
          w_stop_nx    = stop_after;
          w_ack_err_nx = 1'b0;
          w_busy_nx    = 1'b1;
          w_phase_nx   = Q0;
          w_bitcnt_nx  = '0;
          // HOLD already owns the bus, so skip the START condition
          w_state_nx   = (r_state == IDLE) ? START : BIT;
        end
      end
      default: begin
        if (w_tick) begin
          w_phase_nx = r_phase + 2'd1;
          if (r_state == ACK && r_phase == Q2) begin
            w_dack_nx    = ~sda_i;
            w_ack_err_nx = sda_i;
          end
          if (r_phase == Q3) begin
            case (r_state)
              START: begin
                w_state_nx  = BIT;
                w_bitcnt_nx = '0;
              end
              BIT: begin
                w_shift_nx = {r_shift[6:0], 1'b0};
                w_dec_nx   = 1'b1;
                if (r_bitcnt == c_last_bit) w_state_nx = ACK;
                else                        w_bitcnt_nx = r_bitcnt + 3'd1;
              end
              ACK: begin
                if (r_ack_err || r_stop) begin
                  w_state_nx = STOP;
                end else begin
                  w_state_nx = HOLD;
                  w_done_nx  = 1'b1;
                  w_busy_nx  = 1'b0;
                end
              end
              STOP: begin
                w_state_nx = IDLE;
                w_done_nx  = 1'b1;
                w_busy_nx  = 1'b0;
              end
              default: ;
            endcase
          end
        end
      end
    endcase

    w_load_nx = (w_state_nx == BIT) && (r_state != BIT);

    // Line levels follow the next state/phase so the registered outputs align with it
    w_scl_nx = 1'b1;
    w_sda_nx = 1'b1;
    case (w_state_nx)
      START: begin
        w_scl_nx = (w_phase_nx < Q2);
        w_sda_nx = 1'b0;
      end
      BIT: begin
        w_scl_nx = (w_phase_nx >= Q2);
        w_sda_nx = w_shift_nx[7];
      end
      ACK:  w_scl_nx = (w_phase_nx >= Q2);
      STOP: begin
        w_scl_nx = (w_phase_nx >= Q2);
        w_sda_nx = (w_phase_nx == Q3);
      end
      HOLD: w_scl_nx = 1'b0;
      default: ;
    endcase
  end

  assign scl_o         = r_scl;
  assign sda_o         = r_sda;
  assign busy          = r_busy;
  assign done          = r_done;
  assign ack_err       = r_ack_err;
  assign load_tx_count = r_load;
  assign dec_tx_count  = r_dec;
  assign data_ack      = r_dack;

endmodule

`default_nettype wire

// File: tb/tb_i2c_byte_tx.sv
// ----------------------------------------------------------------------
// tb_i2c_byte_tx : self-checking bench for i2c_byte_tx with a bus-level model
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module tb_i2c_byte_tx;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       stop_after = 1'b0;
  logic       sda_i, scl_i;
  logic       scl_o, sda_o, busy, done, ack_err, load_tx_count, dec_tx_count, data_ack;

  int errors = 0;
  int checks = 0;

  // cumulative bus observations (monitor only) and per-transfer baselines (stimulus only)
  int          rises = 0, starts_seen = 0, stops_seen = 0;
  int          n_dec = 0, n_load = 0, n_dack = 0, n_done = 0;
  int          stretch_left = 0;
  logic [63:0] hist = '0;
  bit          prev_scl = 1'b1, prev_sda = 1'b1;
  int          rise_base = 0;
  bit          nack_drv = 1'b0, stretch_arm = 1'b0, in_hold = 1'b0;

  always #5 clk = ~clk;

  // slave: pulls SDA low during the ACK slot unless NACKing; may stretch SCL
  assign sda_i = ((rises - rise_base) >= 8 && !nack_drv) ? 1'b0 : sda_o;
  assign scl_i = scl_o & (stretch_left == 0);

  i2c_byte_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .tx_data       (tx_data),
    .stop_after    (stop_after),
    .sda_i         (sda_i),
    .scl_i         (scl_i),
    .scl_o         (scl_o),
    .sda_o         (sda_o),
    .busy          (busy),
    .done          (done),
    .ack_err       (ack_err),
    .load_tx_count (load_tx_count),
    .dec_tx_count  (dec_tx_count),
    .data_ack      (data_ack)
  );

  always @(negedge clk) begin
    if (stretch_left > 0) stretch_left = stretch_left - 1;
    if (!prev_scl && scl_o) begin
      rises = rises + 1;
      hist  = {hist[62:0], sda_o};
      if (stretch_arm && (rises - rise_base) == 4) stretch_left = 20;
    end
    if (prev_scl && scl_o && prev_sda && !sda_o) starts_seen = starts_seen + 1;
    if (prev_scl && scl_o && !prev_sda && sda_o) stops_seen = stops_seen + 1;
    n_dec  = n_dec  + int'(dec_tx_count);
    n_load = n_load + int'(load_tx_count);
    n_dack = n_dack + int'(data_ack);
    n_done = n_done + int'(done);
    prev_scl = scl_o;
    prev_sda = sda_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One byte transfer; expectations come from the bus-level rules of the protocol.
  task automatic xfer(input logic [7:0] b, input bit stp, input bit nack,
                      input bit stretch, input bit spam);
    int lat, exp_lat, r, sb, pb, db, lb, ab, nb, stretch_cyc;
    bit from_hold, ends_stop;
    logic [7:0] obs;
    from_hold = in_hold;
    ends_stop = stp || nack;
`ifdef I2C_BYTE_TX_STRETCH_EN
    stretch_cyc = stretch ? 20 : 0;
`else
    stretch_cyc = 0;
`endif
    exp_lat = CLK_DIV * ((from_hold ? 0 : 4) + 4 * 8 + 4 + (ends_stop ? 4 : 0)) + stretch_cyc;

    @(posedge clk); #1;
    start = 1'b1; tx_data = b; stop_after = stp; nack_drv = nack; stretch_arm = stretch;
    rise_base = rises; sb = starts_seen; pb = stops_seen;
    db = n_dec; lb = n_load; ab = n_dack; nb = n_done;
    @(posedge clk); #1;
    start = 1'b0; tx_data = 8'($urandom); stop_after = 1'($urandom);
    chk("busy_rise", busy, 1);
    chk("ack_err_clear", ack_err, 0);

    lat = 0;
    while (!done && lat < 1000) begin
      if (spam) begin start = 1'($urandom); tx_data = 8'($urandom); end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("latency", lat, exp_lat);
    chk("busy_fall", busy, 0);

    @(negedge clk);
    r = rises - rise_base;
    for (int j = 0; j < 8; j++) obs[7-j] = (r - 1 - j >= 0) ? hist[r-1-j] : 1'bx;
    chk("sda_bits", obs, b);
    chk("scl_rises", r, ends_stop ? 10 : 9);
    chk("start_cond", starts_seen - sb, from_hold ? 0 : 1);
    chk("stop_cond", stops_seen - pb, ends_stop ? 1 : 0);
    chk("dec_count", n_dec - db, 8);
    chk("load_count", n_load - lb, 1);
    chk("data_ack_count", n_dack - ab, nack ? 0 : 1);
    chk("ack_err", ack_err, nack);
    chk("lines_after", {scl_o, sda_o}, ends_stop ? 2'b11 : 2'b01);
    @(posedge clk); #1;
    chk("done_count", n_done - nb, 1);
    chk("done_pulse_end", done, 0);
    in_hold   = !ends_stop;
    stretch_arm = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {scl_o, sda_o, busy, done, ack_err, load_tx_count, dec_tx_count, data_ack},
        8'b1100_0000);
    rst_n = 1'b1;

    // reset asserted in the middle of bit 1 of 0xA5
    @(posedge clk); #1;
    start = 1'b1; tx_data = 8'hA5; stop_after = 1'b1; nack_drv = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (35) @(posedge clk);
    #1;
    chk("midbit_busy", busy, 1);
    chk("midbit_lines", {scl_o, sda_o}, {1'b0, 1'b0});
    rst_n = 1'b0;
    #1;
    chk("async_reset_lines", {scl_o, sda_o, busy}, 3'b110);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_hold = 1'b0;

    // full transfer after reset, with STOP and ACK
    xfer(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);

    // multi-byte write via HOLD
    xfer(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_lines", {scl_o, sda_o}, 2'b01);
    xfer(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);

    // NACK from HOLD with stop_after=0 forces STOP
    xfer(8'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);

    // start spammed during a transfer
    xfer(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);

    // slave stretches SCL at bit 3
    xfer(8'($urandom), 1'b1, 1'b0, 1'b1, 1'b0);

    // randomized transfers
    for (int k = 0; k < 6; k++) begin
      xfer(8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1'b0, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/i2c_byte_tx.md
# i2c_byte_tx

I2C master byte transmitter: accepts one byte from the host, generates the START condition, shifts the byte MSB-first on SDA with SCL, samples the slave ACK, and optionally issues STOP. It sits directly upstream of the team's transmit bit counter and drives that counter's load, decrement and data-ack strobes, so bit counting in the counter stays in lock-step with the bus.

## Interface
- CLK_DIV, 4, system clocks per SCL quarter-period; minimum 2.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to send tx_data.
- tx_data  in  8  byte to transmit; latched when start is accepted.
- stop_after  in  1  issue STOP after the ACK; latched with tx_data.
- sda_i  in  1  sampled SDA line.
- scl_i  in  1  sampled SCL line; used only for clock stretching.
- scl_o  out  1  SCL drive (1 = release).
- sda_o  out  1  SDA drive (1 = release).
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at the end of a transfer.
- ack_err  out  1  slave NACKed the last byte; sticky until the next accepted start.
- load_tx_count  out  1  one-cycle strobe to reload the bit counter.
- dec_tx_count  out  1  one-cycle strobe per transmitted bit.
- data_ack  out  1  one-cycle strobe when an ACK is received.

## Operation
- States: IDLE, START, BIT, ACK, STOP, HOLD.
- Reset: state is IDLE. scl_o=1, sda_o=1. busy, done, ack_err and all strobes are 0. Lines are released immediately, including when reset is asserted mid-transfer.
- IDLE: start latches tx_data and stop_after, clears ack_err, then moves to START.
- HOLD (bus owned, SCL low): start latches the new byte and goes straight to BIT with no START condition. This is how multi-byte writes are built.
- START: sda_o=0 for quarters 0–1 with SCL high; scl_o=0 for quarters 2–3. Then go to BIT.
- BIT: each bit takes 4 quarters.
  - q0: scl low; sda_o takes shift[7].
  - q1: scl low.
  - q2–q3: scl high.
  - End of q3: shift left and pulse dec_tx_count.
  - After the 8th bit, go to ACK.
- ACK: sda_o=1 (released) for all 4 quarters. sda_i is sampled on the last clk of q2.
  - Sample 0: pulse data_ack.
  - Sample 1: set ack_err.
- After ACK:
  - ack_err=1 → STOP (forced, regardless of stop_after).
  - stop_after=1 → STOP.
  - otherwise → HOLD, with scl_o=0 and sda_o=1.
- STOP:
  - q0–q1: scl low, sda_o=0.
  - q2: scl high.
  - q3: sda_o=1.
  - Then go to IDLE.
- start while busy=1 is ignored. tx_data changes after acceptance have no effect.

## Timing
- Quarter tick: a counter runs 0..CLK_DIV-1 and advances the phase on wrap.
- busy rises the cycle after start is accepted and falls in the same cycle that done pulses.
- load_tx_count pulses on the first clk of the first BIT quarter.
- Outputs are registered. SCL/SDA change only at quarter boundaries.
- Transfer length in quarters: START 4 + BIT 32 + ACK 4, plus STOP 4 when taken.
  - CLK_DIV=4 from IDLE: done pulses 160 cycles after accept without STOP, 176 with STOP.
  - From HOLD, subtract 16 cycles.
- Strobe count per byte: exactly 1 load_tx_count, 8 dec_tx_count, and 0 or 1 data_ack.

## Configuration
- I2C_BYTE_TX_STRETCH_EN defined: entering any q2 (scl released), the quarter counter holds until scl_i=1, so a slave can stretch the clock.
- Undefined: scl_i is ignored and timing is purely CLK_DIV-based. The port remains in both builds.

## Structure
- Shared package i2c_pkg holds:
  - the state enum (IDLE, START, BIT, ACK, STOP, HOLD);
  - quarter-phase constants Q0–Q3;
  - BITS_PER_BYTE=8.
- One sub-module, i2c_scl_timer: the quarter-tick generator, with CLK_DIV, stretch hold and the tick output.

## Test plan
- Reset mid-BIT (CLK_DIV=4, byte 0xA5): assert rst_n=0 → scl_o=1, sda_o=1, busy=0 within the same cycle. Release, then start → full transfer from START.
- Byte 0xA5, stop_after=1, sda_i=0 during ACK:
  - SDA bits 1,0,1,0,0,1,0,1 sampled at each SCL rise;
  - 8 dec_tx_count pulses, 1 data_ack pulse;
  - done at cycle 176; ack_err=0.
- Byte 0x3C, stop_after=0, then a second start with 0xFF while in HOLD:
  - no second START condition;
  - second done 144 cycles after the second accept;
  - scl_o=0 held between bytes.
- NACK (sda_i=1 during ACK), stop_after=0: ack_err=1, STOP is issued anyway, and the block returns to IDLE with both lines released.
- start pulsed repeatedly during a transfer: ignored; the latched byte is unchanged and exactly one done pulse occurs.
- With I2C_BYTE_TX_STRETCH_EN, hold scl_i=0 for 20 cycles at bit-3 q2 → done is delayed by exactly 20 cycles. Without the macro, timing is unchanged.
